note_scheduler: RTL and testbench
=================================

Name: note_scheduler

Overview:
- Monophonic key/octave controller that sits between the board's raw note buttons and octave buttons and the tone-generator/amplifier block.
- Synchronises and debounces every input, then arbitrates multiple held keys with last-pressed priority.
- Enforces a minimum audible note duration and tracks the current octave.
- Drives the generator's 3-bit note code (0 = silent, 1..7 = C..B) and 3-bit octave shift.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles needed before a debounced level changes (10 ms at 100 MHz).
- MIN_HOLD_CYCLES, 5000000, minimum cycles a note stays on the output after its press (50 ms).
- OCT_DEFAULT, 3, octave value after reset.
- OCT_MAX, 7, upper saturation limit for octave (must be ≤ 7).

Ports:
- clk_100M  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- keys  input  7  raw note buttons; bit i = note code i+1 (bit0 = C, bit6 = B); asynchronous, bouncy.
- oct_up  input  1  raw octave-up button.
- oct_dn  input  1  raw octave-down button.
- note  output  3  note code to tone generator; 0 = silent.
- octave  output  3  octave shift to tone generator.
- playing  output  1  high whenever note ≠ 0.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - note = 0, playing = 0, octave = OCT_DEFAULT.
  - FSM = IDLE.
  - All synchroniser flops, debounced levels, previous-level flops and counters = 0.
- Input conditioning (9 independent channels: keys[6:0], oct_up, oct_dn):
  - 2-flop synchroniser per channel.
  - Per-channel debounce counter: whenever the synchronised value equals the debounced value, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the debounced value takes the synchronised value and the counter clears.
  - A rising edge is debounced 1 while the previous-cycle debounced level is 0.
- Octave:
  - oct_up rising edge: octave+1, saturating at OCT_MAX.
  - oct_dn rising edge: octave−1, saturating at 0.
  - Both edges in the same cycle: no change.
  - A change takes effect on the next cycle and is independent of the note FSM, including mid-note.
- Note FSM, states IDLE / PLAY / HOLD. sel is the selected key index, 0..6; hold_cnt is a 32-bit saturating counter.
  - IDLE: note = 0. Any key rising edge → PLAY; sel = lowest-index rising key; hold_cnt = 0.
  - PLAY, in priority order:
    1. Any key rising edge → sel = lowest-index rising key; hold_cnt = 0 (last-pressed wins).
    2. Else if debounced keys[sel] = 0 and another key is still held → sel = lowest-index held key; hold_cnt = 0.
    3. Else if debounced keys[sel] = 0 and no key is held → HOLD if hold_cnt < MIN_HOLD_CYCLES−1, otherwise IDLE.
    4. Else stay; hold_cnt increments.
  - HOLD: note stays sel+1; hold_cnt increments.
    - Any key rising edge → PLAY as in IDLE.
    - Else, when hold_cnt reaches MIN_HOLD_CYCLES−1 → IDLE.
  - hold_cnt saturates rather than wrapping.
- Outputs are registered.
  - note = sel+1 in PLAY/HOLD, 0 in IDLE.
  - playing = (note ≠ 0).
  - Output updates 1 cycle after the debounced edge/level change that causes it.
  - Total raw-input-to-output latency = 2 + DEBOUNCE_CYCLES + 1 cycles (± 1 sync sampling cycle).
- Reset asserted mid-note:
  - Outputs go to reset values immediately (asynchronously).
  - After release, keys still held are not treated as pressed until their debounced level rises from 0. Because the debounced flops reset to 0, this happens after DEBOUNCE_CYCLES.
- Bounce shorter than DEBOUNCE_CYCLES never changes the debounced level.

Test Plan (sim parameters: DEBOUNCE_CYCLES = 4, MIN_HOLD_CYCLES = 16, OCT_DEFAULT = 3):
- Reset and bounce rejection:
  - Stimulus: rst_n low, then high; toggle keys[2] every 2 cycles for 20 cycles.
  - Required: note = 0, octave = 3, playing = 0 throughout.
- Single press, long hold:
  - Stimulus: keys[2] high for 40 cycles.
  - Required: note = 3 and playing = 1 from ~7 cycles after the press; note = 0 ~7 cycles after release; HOLD is not entered.
- Minimum hold:
  - Stimulus: keys[0] high for exactly 8 cycles.
  - Required: note = 1 held for 16 cycles from first assertion, then 0.
- Last-pressed priority:
  - Stimulus: hold keys[4]; after 20 cycles also press keys[1]; later release keys[1] while keys[4] is still held.
  - Required: note 5 → 2, then → 5 again on release; playing stays 1 throughout.
- Same-cycle press:
  - Stimulus: keys[6] and keys[3] rise on the same cycle.
  - Required: note = 4.
- Octave saturation and simultaneity:
  - Stimulus: 6 separate oct_up presses.
  - Required: octave reaches 7 and stays.
  - Stimulus: oct_up and oct_dn pressed together.
  - Required: octave unchanged.
  - Stimulus: 9 oct_dn presses.
  - Required: octave = 0.
  - Stimulus: rst_n pulsed low mid-note.
  - Required: note = 0 and octave = 3 immediately.

Source files
------------

// File: rtl/note_scheduler.sv
`timescale 1ns/1ps
// Monophonic key/octave controller: debounces raw buttons, picks the last-pressed key,
// enforces a minimum note length and tracks the octave for the tone generator.
module note_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MIN_HOLD_CYCLES = 5000000,
    parameter int unsigned OCT_DEFAULT     = 3,
    parameter int unsigned OCT_MAX         = 7
) (
    input  logic       clk_100M,
    input  logic       rst_n,
    input  logic [6:0] keys,
    input  logic       oct_up,
    input  logic       oct_dn,
    output logic [2:0] note,
    output logic [2:0] octave,
    output logic       playing
);

    localparam int unsigned NumCh = 9;
    localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     HoldLast = 32'(MIN_HOLD_CYCLES - 1);
    localparam logic [2:0]      OctDef   = 3'(OCT_DEFAULT);
    localparam logic [2:0]      OctMax   = 3'(OCT_MAX);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPlay = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    logic [NumCh-1:0] sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
    logic [CntW-1:0]  cnt_q [NumCh];
    logic [CntW-1:0]  cnt_d [NumCh];

    logic [1:0]  state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] hold_q, hold_d, hold_inc;
    logic [2:0]  octave_q, octave_d;
    logic [2:0]  note_q, note_d;
    logic        playing_q, playing_d;

    logic [6:0] key_rise, key_held;
    logic       up_rise, dn_rise;

    function automatic logic [2:0] lowest(input logic [6:0] v);
        lowest = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) lowest = 3'(i);
        end
    endfunction

    // Debounce: level follows the synchronised input only after CntLast+1 mismatching cycles
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NumCh; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign key_rise = deb_q[6:0] & ~deb_prev_q[6:0];
    assign key_held = deb_q[6:0];
    assign up_rise  = deb_q[7] & ~deb_prev_q[7];
    assign dn_rise  = deb_q[8] & ~deb_prev_q[8];
    assign hold_inc = (hold_q == '1) ? hold_q : hold_q + 32'd1;

    always_comb begin
        octave_d = octave_q;
        if (up_rise && !dn_rise && octave_q < OctMax) begin
            octave_d = octave_q + 3'd1;
        end else if (dn_rise && !up_rise && octave_q != 3'd0) begin
            octave_d = octave_q - 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                if (|key_rise) begin
                    state_d = StPlay;
                    sel_d   = lowest(key_rise);
                    hold_d  = '0;
                end
            end
            StPlay: begin
                if (|key_rise) begin
                    sel_d  = lowest(key_rise);
                    hold_d = '0;
                end else if (!key_held[sel_q] && |key_held) begin
                    sel_d  = lowest(key_held);
                    hold_d = '0;
                end else if (!key_held[sel_q]) begin
                    state_d = (hold_q < HoldLast) ? StHold : StIdle;
                    hold_d  = hold_inc;
                end else begin
                    hold_d = hold_inc;
                end
            end
            StHold: begin
                if (|key_rise) begin
                    state_d = StPlay;
                    sel_d   = lowest(key_rise);
                    hold_d  = '0;
                end else begin
                    if (hold_q >= HoldLast) state_d = StIdle;
                    hold_d = hold_inc;
                end
            end
            default: state_d = StIdle;
        endcase
        note_d    = (state_d == StIdle) ? 3'd0 : sel_d + 3'd1;
        playing_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '{default: '0};
            state_q    <= StIdle;
            sel_q      <= 3'd0;
            hold_q     <= '0;
            octave_q   <= OctDef;
            note_q     <= 3'd0;
            playing_q  <= 1'b0;
        end else begin
            sync1_q    <= {oct_dn, oct_up, keys};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            octave_q   <= octave_d;
            note_q     <= note_d;
            playing_q  <= playing_d;
        end
    end

    assign note    = note_q;
    assign octave  = octave_q;
    assign playing = playing_q;

endmodule

// File: tb/tb_note_scheduler.sv
`timescale 1ns/1ps
// Bench for note_scheduler: table of input steps with expected outputs queued on a
// cycle-stamped scoreboard, plus hand-written minimum-hold and reset sequences.
module tb_note_scheduler;

    localparam int unsigned DEB     = 4;
    localparam int unsigned HOLD    = 16;
    localparam int unsigned OCT_DEF = 3;
    localparam int unsigned LAT     = 2 + DEB + 1;

    logic       clk_100M = 1'b0;
    logic       rst_n    = 1'b0;
    logic [6:0] keys     = '0;
    logic       oct_up   = 1'b0;
    logic       oct_dn   = 1'b0;
    logic [2:0] note, octave;
    logic       playing;

    note_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .MIN_HOLD_CYCLES(HOLD),
        .OCT_DEFAULT    (OCT_DEF),
        .OCT_MAX        (7)
    ) dut (
        .clk_100M(clk_100M),
        .rst_n   (rst_n),
        .keys    (keys),
        .oct_up  (oct_up),
        .oct_dn  (oct_dn),
        .note    (note),
        .octave  (octave),
        .playing (playing)
    );

    always #5 clk_100M = ~clk_100M;

    int unsigned cyc = 0;
    always @(posedge clk_100M) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int unsigned due;
        logic [2:0]  note;
        logic [2:0]  oct;
        string       name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [6:0]  keys;
        logic        up;
        logic        dn;
        int unsigned len;
        logic [2:0]  pre_note;
        logic [2:0]  pre_oct;
        logic [2:0]  exp_note;
        logic [2:0]  exp_oct;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic compare(input string name, input logic [2:0] n, input logic [2:0] o,
                           input logic p, input logic [2:0] en, input logic [2:0] eo);
        logic ep;
        ep = (en != 3'd0);
        tests++;
        if (n !== en || o !== eo || p !== ep) begin
            fails++;
            $display("FAIL %s @cyc %0d: got note=%0d octave=%0d playing=%0d, want note=%0d octave=%0d playing=%0d",
                     name, cyc, n, o, p, en, eo, ep);
        end
    endtask

    task automatic expect_at(input int unsigned off, input logic [2:0] n, input logic [2:0] o,
                             input string name);
        exp_t e;
        e.due  = cyc + off;
        e.note = n;
        e.oct  = o;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input logic [6:0] k, input logic u, input logic d, input int unsigned len);
        keys   = k;
        oct_up = u;
        oct_dn = d;
        repeat (len) @(posedge clk_100M);
        #1;
    endtask

    function automatic void add(input logic [6:0] k, input logic u, input logic d,
                                input int unsigned len, input logic [2:0] pn, input logic [2:0] po,
                                input logic [2:0] en, input logic [2:0] eo, input string name);
        vec_t v;
        v.keys = k; v.up = u; v.dn = d; v.len = len;
        v.pre_note = pn; v.pre_oct = po; v.exp_note = en; v.exp_oct = eo; v.name = name;
        tbl.push_back(v);
    endfunction

    // Scoreboard consumer: compare every queued expectation on its due cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100M);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                compare(e.name, note, octave, playing, e.note, e.oct);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int o, n;

        // Stimulus table: each row drives inputs for len cycles; outputs checked at LAT-1 and LAT
        add(7'b0000100, 0, 0, 40, 0, 3, 3, 3, "long_press");
        add(7'b0000000, 0, 0, 20, 3, 3, 0, 3, "long_release_no_hold");
        add(7'b0010000, 0, 0, 20, 0, 3, 5, 3, "prio_first");
        add(7'b0010010, 0, 0, 20, 5, 3, 2, 3, "prio_last_wins");
        add(7'b0010000, 0, 0, 20, 2, 3, 5, 3, "prio_fallback");
        add(7'b0000000, 0, 0, 30, 5, 3, 0, 3, "prio_release");
        add(7'b1001000, 0, 0, 30, 0, 3, 4, 3, "same_cycle");
        add(7'b0000000, 0, 0, 30, 4, 3, 0, 3, "same_cycle_release");
        o = 3;
        for (int i = 0; i < 6; i++) begin
            n = (o < 7) ? o + 1 : 7;
            add(7'b0, 1, 0, 8, 0, 3'(o), 0, 3'(n), "oct_up");
            add(7'b0, 0, 0, 8, 0, 3'(n), 0, 3'(n), "oct_up_rel");
            o = n;
        end
        add(7'b0, 1, 1, 8, 0, 3'(o), 0, 3'(o), "oct_both");
        add(7'b0, 0, 0, 8, 0, 3'(o), 0, 3'(o), "oct_both_rel");
        for (int i = 0; i < 9; i++) begin
            n = (o > 0) ? o - 1 : 0;
            add(7'b0, 0, 1, 8, 0, 3'(o), 0, 3'(n), "oct_dn");
            add(7'b0, 0, 0, 8, 0, 3'(n), 0, 3'(n), "oct_dn_rel");
            o = n;
        end

        // Reset values while reset is held
        repeat (3) @(posedge clk_100M);
        #1;
        compare("reset", note, octave, playing, 3'd0, 3'(OCT_DEF));
        rst_n = 1'b1;

        // Bounce shorter than the debounce window must never reach the output
        for (int i = 0; i < 10; i++) begin
            expect_at(1, 0, 3, "bounce");
            expect_at(2, 0, 3, "bounce");
            step((i % 2 == 0) ? 7'b0000100 : 7'b0000000, 0, 0, 2);
        end
        expect_at(LAT, 0, 3, "bounce_settle");
        step(7'b0, 0, 0, 10);

        // Short press: note must stay on for HOLD cycles from first assertion
        for (int k = 1; k <= 26; k++) begin
            expect_at(k, (k >= LAT && k < LAT + HOLD) ? 3'd1 : 3'd0, 3, "min_hold");
        end
        step(7'b0000001, 0, 0, 8);
        step(7'b0000000, 0, 0, 30);

        foreach (tbl[i]) begin
            expect_at(LAT - 1, tbl[i].pre_note, tbl[i].pre_oct, {tbl[i].name, "_pre"});
            expect_at(LAT, tbl[i].exp_note, tbl[i].exp_oct, tbl[i].name);
            step(tbl[i].keys, tbl[i].up, tbl[i].dn, tbl[i].len);
        end

        // Reset asserted mid-note; held key re-plays only after a fresh debounce
        expect_at(LAT, 6, 0, "pre_rst_note");
        step(7'b0100000, 0, 0, 12);
        rst_n = 1'b0;
        #2;
        compare("rst_async", note, octave, playing, 3'd0, 3'(OCT_DEF));
        repeat (2) @(posedge clk_100M);
        #1;
        compare("rst_held", note, octave, playing, 3'd0, 3'(OCT_DEF));
        rst_n = 1'b1;
        expect_at(LAT - 1, 0, 3, "rst_rel_pre");
        expect_at(LAT, 6, 3, "rst_rel_note");
        step(7'b0100000, 0, 0, 30);
        expect_at(LAT, 0, 3, "rst_rel_release");
        step(7'b0000000, 0, 0, 20);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
